// File: rtl/kanagawa_race_counter_scanner.sv
// Readout sequencer for a bank of race counters: it snapshots all counters in one cycle,
// optionally pulses their clears, and then streams one counter per valid/ready beat.
// Optional macro: KANAGAWA_RACE_SCAN_TOTAL_EN adds a final beat that carries the snapshot sum.
// Latency: the first beat is valid the cycle after the scan is accepted; beats hold while out_ready_i is low.
module kanagawa_race_counter_scanner #(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int INDEX_WIDTH   = $clog2(NUM_COUNTERS+1),
  parameter int SUM_WIDTH     = COUNTER_WIDTH+$clog2(NUM_COUNTERS)+1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_in_i,
  input  logic                                  scan_req_i,
  input  logic                                  scan_clear_i,
  output logic                                  scan_busy_o,
  output logic                                  scan_done_o,
  output logic [NUM_COUNTERS-1:0]               counter_clear_out_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [INDEX_WIDTH-1:0]                out_index_o,
  output logic [SUM_WIDTH-1:0]                  out_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
    ST_TOTAL = 2'd2,
`endif
    ST_SEND  = 2'd1
  } state_e;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_COUNTERS-1);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] snap_q [NUM_COUNTERS];
  logic [INDEX_WIDTH-1:0]   idx_q;
  logic                     clear_pending_q;
  logic                     done_q, done_d;
  logic [COUNTER_WIDTH-1:0] snap_sel;
  logic [SUM_WIDTH-1:0]     snap_sel_ext;
  logic                     accept;
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
  logic [SUM_WIDTH-1:0]     acc_q;
`endif

  assign accept = (state_q == ST_IDLE) && scan_req_i;

  // Select the snapshot entry addressed by the current beat index.
  always_comb begin
    snap_sel = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx_q == INDEX_WIDTH'(i)) snap_sel = snap_q[i];
    end
    snap_sel_ext = {{(SUM_WIDTH-COUNTER_WIDTH){1'b0}}, snap_sel};
  end

  // State register; a reset drops any in-flight scan.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus the done pulse raised when the final beat is accepted.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (scan_req_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready_i && (idx_q == LAST_IDX)) begin
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
          state_d = ST_TOTAL;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
      ST_TOTAL: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so out_ready_i never reaches out_valid_o.
  always_comb begin
    scan_busy_o         = 1'b0;
    out_valid_o         = 1'b0;
    out_index_o         = '0;
    out_count_o         = '0;
    counter_clear_out_o = '0;
    scan_done_o         = done_q;
    case (state_q)
      ST_SEND: begin
        scan_busy_o         = 1'b1;
        out_valid_o         = 1'b1;
        out_index_o         = idx_q;
        out_count_o         = snap_sel_ext;
        counter_clear_out_o = {NUM_COUNTERS{clear_pending_q}};
      end
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
      ST_TOTAL: begin
        scan_busy_o = 1'b1;
        out_valid_o = 1'b1;
        out_index_o = INDEX_WIDTH'(NUM_COUNTERS);
        out_count_o = acc_q;
      end
`endif
      default: ;
    endcase
  end

  // Datapath: snapshot capture, beat index, running sum and the one-shot clear flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_COUNTERS; i++) snap_q[i] <= '0;
      idx_q           <= '0;
      clear_pending_q <= 1'b0;
      done_q          <= 1'b0;
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
      acc_q           <= '0;
`endif
    end else begin
      done_q <= done_d;
      if (accept) begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          snap_q[i] <= counters_in_i[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        end
        idx_q           <= '0;
        clear_pending_q <= scan_clear_i;
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
        acc_q           <= '0;
`endif
      end else if (state_q == ST_SEND) begin
        // The clear is only ever driven during the first SEND cycle.
        clear_pending_q <= 1'b0;
        if (out_ready_i) begin
          idx_q <= idx_q + 1'b1;
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
          acc_q <= acc_q + snap_sel_ext;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_kanagawa_race_counter_scanner.sv
// Self-checking bench for kanagawa_race_counter_scanner using directed and random scans.
// The reference model is a queue of expected beats that is built when a scan is accepted.
// Set KANAGAWA_RACE_SCAN_TOTAL_EN to match the DUT build so that the total beat is expected.
module tb_kanagawa_race_counter_scanner;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int IW = $clog2(N+1);
  localparam int SW = CW+$clog2(N)+1;
`ifdef KANAGAWA_RACE_SCAN_TOTAL_EN
  localparam bit TOT = 1'b1;
`else
  localparam bit TOT = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [N*CW-1:0] counters_in;
  logic          scan_req;
  logic          scan_clear;
  logic          scan_busy;
  logic          scan_done;
  logic [N-1:0]  counter_clear_out;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [SW-1:0] out_count;

  logic [CW-1:0] cnt [N];

  kanagawa_race_counter_scanner #(
    .NUM_COUNTERS(N), .COUNTER_WIDTH(CW), .INDEX_WIDTH(IW), .SUM_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .counters_in_i(counters_in),
    .scan_req_i(scan_req), .scan_clear_i(scan_clear),
    .scan_busy_o(scan_busy), .scan_done_o(scan_done),
    .counter_clear_out_o(counter_clear_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_index_o(out_index), .out_count_o(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    counters_in = '0;
    for (int i = 0; i < N; i++) counters_in[i*CW +: CW] = cnt[i];
  end

  // Reference model: pending beats of the current scan plus expected one-cycle pulses.
  int            q_idx [$];
  int            q_cnt [$];
  bit            m_done;
  bit            m_clr;
  int            n_cmp;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check the outputs.
  task automatic cycle();
    bit          r_rst, r_req, r_clr, r_rdy, clear_seen;
    int          snap [N];
    int          sum;
    r_rst = rst; r_req = scan_req; r_clr = scan_clear; r_rdy = out_ready;
    clear_seen = (counter_clear_out != '0);
    for (int i = 0; i < N; i++) snap[i] = int'(cnt[i]);
    @(posedge clk);
    m_done = 1'b0;
    m_clr  = 1'b0;
    if (r_rst) begin
      q_idx.delete();
      q_cnt.delete();
    end else if (q_idx.size() > 0) begin
      if (r_rdy) begin
        void'(q_idx.pop_front());
        void'(q_cnt.pop_front());
        if (q_idx.size() == 0) m_done = 1'b1;
      end
    end else if (r_req) begin
      sum = 0;
      for (int i = 0; i < N; i++) begin
        q_idx.push_back(i);
        q_cnt.push_back(snap[i]);
        sum += snap[i];
      end
      if (TOT) begin
        q_idx.push_back(N);
        q_cnt.push_back(sum);
      end
      m_clr = r_clr;
    end
    #1;
    // The bench acts as the counter bank: a clear seen at the edge zeroes the counters.
    if (clear_seen) for (int i = 0; i < N; i++) cnt[i] = '0;
    chk("busy",  32'(scan_busy), 32'(q_idx.size() > 0));
    chk("valid", 32'(out_valid), 32'(q_idx.size() > 0));
    chk("done",  32'(scan_done), 32'(m_done));
    chk("clear", 32'(counter_clear_out), m_clr ? 32'((1 << N) - 1) : 32'd0);
    if (q_idx.size() > 0) begin
      chk("index", 32'(out_index), 32'(q_idx[0]));
      chk("count", 32'(out_count), 32'(q_cnt[0]));
    end else if (r_rst) begin
      chk("rst_index", 32'(out_index), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_done = 1'b0; m_clr = 1'b0;
    rst = 1'b1; scan_req = 1'b0; scan_clear = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) cnt[i] = '0;

    // Reset state.
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Basic scan with counters 3,0,255,7 and out_ready held high.
    cnt[0] = 8'd3; cnt[1] = 8'd0; cnt[2] = 8'd255; cnt[3] = 8'd7;
    scan_req = 1'b1;
    cycle();
    scan_req = 1'b0;
    repeat (N + 3) cycle();

    // Backpressure: out_ready low for 3 cycles before each accepted beat.
    scan_req = 1'b1; out_ready = 1'b0;
    cycle();
    scan_req = 1'b0;
    for (int b = 0; b < N + 1; b++) begin
      out_ready = 1'b0;
      repeat (3) cycle();
      out_ready = 1'b1;
      cycle();
    end
    repeat (2) cycle();

    // Clear: the pulse comes one cycle after acceptance; a follow-up scan then reads zeros.
    cnt[0] = 8'd9; cnt[1] = 8'd128; cnt[2] = 8'd1; cnt[3] = 8'd200;
    scan_req = 1'b1; scan_clear = 1'b1;
    cycle();
    scan_req = 1'b0; scan_clear = 1'b0;
    repeat (N + 2) cycle();
    scan_req = 1'b1;
    cycle();
    scan_req = 1'b0;
    repeat (N + 2) cycle();

    // Busy rejection: scan_req held high while counters change every cycle.
    scan_req = 1'b1;
    for (int c = 0; c < 3 * (N + 2); c++) begin
      for (int i = 0; i < N; i++) cnt[i] = CW'($urandom_range(0, 255));
      cycle();
    end
    scan_req = 1'b0;
    repeat (N + 2) cycle();

    // Reset while beat 2 is pending.
    scan_req = 1'b1;
    cycle();
    scan_req = 1'b0;
    repeat (2) cycle();
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Random traffic including occasional resets and clears.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        cnt[i] = ($urandom_range(0, 3) == 0) ? CW'(255) : CW'($urandom_range(0, 255));
      scan_req   = ($urandom_range(0, 2) == 0);
      scan_clear = ($urandom_range(0, 1) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 60) == 0);
      cycle();
    end
    rst = 1'b0; scan_req = 1'b0; out_ready = 1'b1;
    repeat (N + 3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
